// File: rtl/viterbi_ber_monitor_pkg.sv
// Shared constants, FSM state type and the rate-1/2 K=3 encoder function for the BER monitor.
// Latency: n/a (combinational helpers only). Backpressure: n/a.
package viterbi_pkg;
    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    localparam int WINDOW_DEF = 256;
    localparam int DEPTH_DEF  = 64;
    localparam int CW_DEF     = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Register layout is {current bit, previous bit, bit before that}.
    function automatic logic [1:0] conv_sym(input logic [K-1:0] shreg);
        return {^(shreg & G0), ^(shreg & G1)};
    endfunction
endpackage

// File: rtl/viterbi_ber_monitor_fifo.sv
// Reference FIFO holding transmitted data until the matching decoder/channel event pops it.
// Latency: push visible to pop next cycle; empty push+pop bypasses combinationally.
// Backpressure: none; caller decides on full/empty, pushes to full without a pop are ignored.
module ber_ref_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             pop_vld,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_wr;
    logic             do_rd;
    logic             bypass;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign bypass  = push & pop & empty;
    assign do_wr   = push & (~full | pop) & ~bypass;
    assign do_rd   = pop & ~empty;
    assign pop_vld = pop & (~empty | push);
    assign pop_dat = empty ? push_dat : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)
                level <= level + 1'b1;
            else if (do_rd && !do_wr)
                level <= level - 1'b1;
        end
    end
endmodule

// File: rtl/viterbi_ber_monitor.sv
// Measures decoded-bit and channel-symbol error counts over fixed windows of compared bits.
// Latency: events land in running counters one clock after sampling; window results one clock after the last bit.
// Backpressure: none; FIFO overrun/underrun drop the event and raise sticky flags.
module viterbi_ber_monitor
    import viterbi_pkg::*;
#(
    parameter int WINDOW = WINDOW_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CW     = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tx_bit_i,
    input  logic          tx_valid_i,
    input  logic [1:0]    chan_sym_i,
    input  logic          chan_valid_i,
    input  logic          rx_bit_i,
    input  logic          rx_valid_i,
    output logic [CW-1:0] win_bit_err_o,
    output logic [CW-1:0] win_sym_err_o,
    output logic [CW-1:0] win_bits_o,
    output logic          window_done_o,
    output logic          running_o,
    output logic          overflow_o,
    output logic          underflow_o
);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] CMAX = '1;

    state_t        state;
    logic          b1, b2;
    logic [1:0]    exp_sym;
    logic          bit_ref, bit_vld, bit_full, bit_empty;
    logic [1:0]    sym_ref;
    logic          sym_vld, sym_full, sym_empty;
    logic [1:0]    sym_diff;
    logic [1:0]    sym_inc;
    logic          bit_inc;
    logic          boundary;
    logic [WW-1:0] win_pos;
    logic [CW-1:0] run_bits, run_bit_err, run_sym_err;
    logic [CW-1:0] nxt_bits, nxt_bit_err, nxt_sym_err;

    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [1:0] inc);
        logic [CW:0] s;
        s = {1'b0, a} + {{(CW-1){1'b0}}, inc};
        return s[CW] ? CMAX : s[CW-1:0];
    endfunction

    assign exp_sym = conv_sym({tx_bit_i, b1, b2});

    ber_ref_fifo #(.WIDTH(1), .DEPTH(DEPTH)) u_bit_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_valid_i),
        .push_dat (tx_bit_i),
        .pop      (rx_valid_i),
        .pop_dat  (bit_ref),
        .pop_vld  (bit_vld),
        .full     (bit_full),
        .empty    (bit_empty)
    );

    ber_ref_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_sym_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_valid_i),
        .push_dat (exp_sym),
        .pop      (chan_valid_i),
        .pop_dat  (sym_ref),
        .pop_vld  (sym_vld),
        .full     (sym_full),
        .empty    (sym_empty)
    );

    assign sym_diff    = sym_ref ^ chan_sym_i;
    assign sym_inc     = sym_vld ? {sym_diff[1] & sym_diff[0], sym_diff[1] ^ sym_diff[0]} : 2'd0;
    assign bit_inc     = bit_vld & (bit_ref != rx_bit_i);
    assign boundary    = bit_vld & (win_pos == WW'(WINDOW - 1));
    assign nxt_bits    = sat_add(run_bits,    {1'b0, bit_vld});
    assign nxt_bit_err = sat_add(run_bit_err, {1'b0, bit_inc});
    assign nxt_sym_err = sat_add(run_sym_err, sym_inc);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            running_o     <= 1'b0;
            b1            <= 1'b0;
            b2            <= 1'b0;
            win_pos       <= '0;
            run_bits      <= '0;
            run_bit_err   <= '0;
            run_sym_err   <= '0;
            win_bits_o    <= '0;
            win_bit_err_o <= '0;
            win_sym_err_o <= '0;
            window_done_o <= 1'b0;
            overflow_o    <= 1'b0;
            underflow_o   <= 1'b0;
        end else begin
            if (state == IDLE && rx_valid_i) begin
                state     <= RUN;
                running_o <= 1'b1;
            end
            if (tx_valid_i) begin
                b2 <= b1;
                b1 <= tx_bit_i;
            end
            if (bit_vld)
                win_pos <= win_pos + 1'b1;
            // Everything sampled on the closing edge belongs to the closing window.
            if (boundary) begin
                win_bits_o    <= nxt_bits;
                win_bit_err_o <= nxt_bit_err;
                win_sym_err_o <= nxt_sym_err;
                run_bits      <= '0;
                run_bit_err   <= '0;
                run_sym_err   <= '0;
                window_done_o <= 1'b1;
            end else begin
                run_bits      <= nxt_bits;
                run_bit_err   <= nxt_bit_err;
                run_sym_err   <= nxt_sym_err;
                window_done_o <= 1'b0;
            end
            if (tx_valid_i && ((bit_full && !rx_valid_i) || (sym_full && !chan_valid_i)))
                overflow_o <= 1'b1;
            if ((rx_valid_i && bit_empty && !tx_valid_i) || (chan_valid_i && sym_empty && !tx_valid_i))
                underflow_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed bench for viterbi_ber_monitor: clean/noisy windows, FIFO overrun/underrun, bypass and mid-window reset.
module tb_viterbi_ber_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_bit_i = 1'b0, tx_valid_i = 1'b0;
    logic [1:0]  chan_sym_i = 2'b00;
    logic        chan_valid_i = 1'b0;
    logic        rx_bit_i = 1'b0, rx_valid_i = 1'b0;
    logic [15:0] win_bit_err_o, win_sym_err_o, win_bits_o;
    logic        window_done_o, running_o, overflow_o, underflow_o;

    int vectors = 0;
    int miscompares = 0;
    logic m1 = 1'b0, m2 = 1'b0;

    viterbi_ber_monitor #(.WINDOW(256), .DEPTH(64), .CW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .tx_bit_i      (tx_bit_i),
        .tx_valid_i    (tx_valid_i),
        .chan_sym_i    (chan_sym_i),
        .chan_valid_i  (chan_valid_i),
        .rx_bit_i      (rx_bit_i),
        .rx_valid_i    (rx_valid_i),
        .win_bit_err_o (win_bit_err_o),
        .win_sym_err_o (win_sym_err_o),
        .win_bits_o    (win_bits_o),
        .window_done_o (window_done_o),
        .running_o     (running_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference encoder: g0 = d^b1^b2, g1 = d^b2.
    function automatic logic [1:0] encode(input logic d);
        logic [1:0] s;
        s  = {d ^ m1 ^ m2, d ^ m2};
        m2 = m1;
        m1 = d;
        return s;
    endfunction

    task automatic idle_inputs();
        tx_valid_i = 1'b0; tx_bit_i = 1'b0;
        chan_valid_i = 1'b0; chan_sym_i = 2'b00;
        rx_valid_i = 1'b0; rx_bit_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        m1 = 1'b0; m2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic step(output int done);
        @(posedge clk); #1;
        done = window_done_o ? 1 : 0;
    endtask

    // n bits: channel symbols lag by 5 cycles, decoder output lags by 20.
    task automatic run_bits(input int n, input bit sym_flip, input int e0, input int e1, input int e2,
                            output int done_cnt);
        logic       bits [300];
        logic [1:0] syms [300];
        int d;
        done_cnt = 0;
        for (int k = 0; k < n; k++) begin
            bits[k] = 1'($urandom);
            syms[k] = encode(bits[k]);
        end
        for (int c = 0; c < n + 25; c++) begin
            tx_valid_i = (c < n);
            tx_bit_i   = (c < n) ? bits[c] : 1'b0;
            chan_valid_i = (c >= 5) && (c - 5 < n);
            chan_sym_i   = 2'b00;
            if (chan_valid_i) begin
                chan_sym_i = syms[c-5];
                if (sym_flip && ((c - 5) % 32 >= 10) && ((c - 5) % 32 <= 13))
                    chan_sym_i[0] = ~chan_sym_i[0];
            end
            rx_valid_i = (c >= 20) && (c - 20 < n);
            rx_bit_i   = 1'b0;
            if (rx_valid_i)
                rx_bit_i = bits[c-20] ^ ((c - 20 == e0) || (c - 20 == e1) || (c - 20 == e2));
            step(d);
            done_cnt += d;
        end
        idle_inputs();
    endtask

    initial begin
        int dn, d;
        logic rec [64];
        logic b;

        // Reset state
        do_reset();
        check("rst_win_bits", win_bits_o, 0);
        check("rst_win_bit_err", win_bit_err_o, 0);
        check("rst_win_sym_err", win_sym_err_o, 0);
        check("rst_done", window_done_o, 0);
        check("rst_running", running_o, 0);
        check("rst_flags", {overflow_o, underflow_o}, 0);

        // Clean channel, rx delayed 20
        run_bits(256, 1'b0, -1, -1, -1, dn);
        check("clean_done_cnt", dn, 1);
        check("clean_bits", win_bits_o, 256);
        check("clean_bit_err", win_bit_err_o, 0);
        check("clean_sym_err", win_sym_err_o, 0);
        check("clean_running", running_o, 1);
        check("clean_overflow", overflow_o, 0);
        check("clean_underflow", underflow_o, 0);

        // Symbol bit flips on indices 10..13 of every 32
        do_reset();
        run_bits(256, 1'b1, -1, -1, -1, dn);
        check("symflip_done_cnt", dn, 1);
        check("symflip_sym_err", win_sym_err_o, 32);
        check("symflip_bit_err", win_bit_err_o, 0);
        check("symflip_bits", win_bits_o, 256);

        // Three inverted decoded bits, one of them the window's last
        do_reset();
        run_bits(256, 1'b0, 7, 100, 255, dn);
        check("biterr_done_cnt", dn, 1);
        check("biterr_bit_err", win_bit_err_o, 3);
        check("biterr_sym_err", win_sym_err_o, 0);

        // Mid-window reset after 100 bits, window outputs still hold previous results
        run_bits(100, 1'b0, -1, -1, -1, dn);
        check("partial_no_done", dn, 0);
        check("partial_win_kept", win_bit_err_o, 3);
        rst = 1'b0;
        #1;
        check("midrst_win_bits", win_bits_o, 0);
        check("midrst_win_bit_err", win_bit_err_o, 0);
        check("midrst_running", running_o, 0);
        check("midrst_done", window_done_o, 0);
        m1 = 1'b0; m2 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        run_bits(256, 1'b0, -1, -1, -1, dn);
        check("postrst_done_cnt", dn, 1);
        check("postrst_bits", win_bits_o, 256);
        check("postrst_bit_err", win_bit_err_o, 0);

        // Overflow: 65 pushes, no pops; 65th must be dropped
        do_reset();
        dn = 0;
        for (int i = 0; i < 64; i++) begin
            rec[i] = 1'($urandom);
            tx_valid_i = 1'b1; tx_bit_i = rec[i];
            step(d);
        end
        check("ovf_before_65th", overflow_o, 0);
        tx_bit_i = ~rec[0];
        step(d);
        check("ovf_after_65th", overflow_o, 1);
        tx_valid_i = 1'b0;
        for (int i = 0; i < 64; i++) begin
            rx_valid_i = 1'b1; rx_bit_i = rec[i];
            step(d);
            dn += d;
        end
        for (int i = 0; i < 192; i++) begin
            b = 1'($urandom);
            tx_valid_i = 1'b1; tx_bit_i = b;
            rx_valid_i = 1'b1; rx_bit_i = b;
            step(d);
            dn += d;
        end
        idle_inputs();
        check("ovf_done_cnt", dn, 1);
        check("ovf_bits", win_bits_o, 256);
        check("ovf_bit_err", win_bit_err_o, 0);
        check("ovf_underflow", underflow_o, 0);

        // Bypass on empty FIFOs, with one underflow pop in the middle
        do_reset();
        dn = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == 128) begin
                idle_inputs();
                rx_valid_i = 1'b1;
                step(d);
                check("udf_flag_set", underflow_o, 1);
            end
            b = 1'($urandom);
            tx_valid_i = 1'b1; tx_bit_i = b;
            chan_valid_i = 1'b1; chan_sym_i = encode(b);
            rx_valid_i = 1'b1; rx_bit_i = b ^ (i == 50);
            step(d);
            dn += d;
            if (i == 127)
                check("bypass_no_udf", underflow_o, 0);
        end
        idle_inputs();
        check("bypass_done_cnt", dn, 1);
        check("bypass_bits", win_bits_o, 256);
        check("bypass_bit_err", win_bit_err_o, 1);
        check("bypass_sym_err", win_sym_err_o, 0);
        check("bypass_overflow", overflow_o, 0);
        step(d);
        check("done_one_cycle", window_done_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
